// File: rtl/vga_timing_source_if.sv
// Counter/colour link between the VGA timing source (master) and the frame buffer controller (slave).
interface vga_timing_source_if;
  logic [9:0] counter_H;
  logic [9:0] counter_V;
  logic       pixel_tick;
  logic       frame_tick;
  logic       colour;

  modport master (
    output counter_H, counter_V, pixel_tick, frame_tick,
    input  colour
  );

  modport slave (
    input  counter_H, counter_V, pixel_tick, frame_tick,
    output colour
  );
endinterface

// File: rtl/vga_timing_source.sv
// 640x480@60 raster timing: pixel prescaler, H/V counters, and sync/blank aligned to frame-buffer colour.
// Define TEST_PATTERN_EN to replace the colour input with a 32x32 checkerboard.
module vga_timing_source #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOUR_LAT = 3
) (
  input  logic                clk_in,
  input  logic                reset,
  vga_timing_source_if.master fb,
  output logic                hsync,
  output logic                vsync,
  output logic                video_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
`ifdef TEST_PATTERN_EN
    logic hb;
    logic vb;
`endif
  } align_t;

  function automatic align_t blank_word();
    align_t w;
    w    = '0;
    w.hs = 1'b1;
    w.vs = 1'b1;
    return w;
  endfunction

  localparam align_t BLANK = blank_word();

  logic [2:0] div_q;
  logic [2:0] div_n;
  logic [9:0] h_q;
  logic [9:0] v_q;
  logic       tick_q;
  logic       frame_q;

  assign div_n = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;

  // tick_q is high exactly while div_q == DIV_LAST, so counters step on the edge that ends the tick cycle.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      div_q   <= div_n;
      tick_q  <= (div_n == DIV_LAST);
      frame_q <= 1'b0;
      if (tick_q) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          if (v_q == V_LAST) begin
            v_q     <= '0;
            frame_q <= 1'b1;
          end else begin
            v_q <= v_q + 10'd1;
          end
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  assign fb.counter_H  = h_q;
  assign fb.counter_V  = v_q;
  assign fb.pixel_tick = tick_q;
  assign fb.frame_tick = frame_q;

  align_t raw;
  align_t dly;

  always_comb begin
    // NOTE: a full default first keeps every field assigned on every path, so no latch is inferred.
    raw    = BLANK;
    raw.de = (h_q < H_VIS) && (v_q < V_VIS);
    raw.hs = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    raw.vs = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
`ifdef TEST_PATTERN_EN
    raw.hb = h_q[5];
    raw.vb = v_q[5];
`endif
  end

  // Delay line matches the frame buffer's colour latency.
  generate
    if (COLOUR_LAT == 0) begin : g_no_delay
      assign dly = raw;
    end else begin : g_delay
      align_t pipe [COLOUR_LAT];

      // NOTE: this shift register is reset on purpose: flushing it to blank stops stale pixels after a restart.
      always_ff @(posedge clk_in) begin
        if (reset) begin
          for (int i = 0; i < COLOUR_LAT; i++) pipe[i] <= BLANK;
        end else begin
          pipe[0] <= raw;
          for (int i = 1; i < COLOUR_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly = pipe[COLOUR_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (reset) begin
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_out <= 1'b0;
    end else begin
      hsync <= dly.hs;
      vsync <= dly.vs;
`ifdef TEST_PATTERN_EN
      video_out <= dly.de & (dly.hb ^ dly.vb);
`else
      video_out <= dly.de & fb.colour;
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_source.sv
// Directed bench: a default-timing instance for reset/line behaviour and a shrunken-raster instance for frame-level behaviour.
`timescale 1ns/1ps
module tb_vga_timing_source;

  localparam int LAT_F  = 3;
  localparam int LAT_S  = 2;
  localparam int DLY_S  = LAT_S + 1;
  localparam int SFRAME = 56 * 39 * 2;
  localparam int NS     = 2 * SFRAME + 8;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic hsync_f, vsync_f, video_f;
  logic hsync_s, vsync_s, video_s;
  int   errors = 0;
  int   checks = 0;

  logic [9:0] hh [0:NS];
  logic [9:0] vv [0:NS];
  logic       hs_a [0:NS];
  logic       vs_a [0:NS];
  logic       vid_a [0:NS];
  logic       ft_a [0:NS];
  logic       col_a [0:NS];

  vga_timing_source_if if_f ();
  vga_timing_source_if if_s ();

  always #5 clk_in = ~clk_in;

  vga_timing_source dut_f (
    .clk_in(clk_in), .reset(reset), .fb(if_f),
    .hsync(hsync_f), .vsync(vsync_f), .video_out(video_f)
  );

  vga_timing_source #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(4), .COLOUR_LAT(LAT_S)
  ) dut_s (
    .clk_in(clk_in), .reset(reset), .fb(if_s),
    .hsync(hsync_s), .vsync(vsync_s), .video_out(video_s)
  );

  // Expected raw decode of the small raster (H_TOTAL 56, V_TOTAL 39).
  function automatic logic s_de(logic [9:0] h, logic [9:0] v);
    return (h < 10'd40) && (v < 10'd30);
  endfunction
  function automatic logic s_hs(logic [9:0] h);
    return !((h >= 10'd44) && (h <= 10'd49));
  endfunction
  function automatic logic s_vs(logic [9:0] v);
    return !((v >= 10'd33) && (v <= 10'd34));
  endfunction

  // Holds reset across one edge; returns on the negedge that is sample index 0.
  task automatic restart();
    reset = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if ({hsync_f, vsync_f, video_f} !== 3'b110) begin
      errors++; $display("FAIL reset_outputs: hs/vs/video got %b want 110", {hsync_f, vsync_f, video_f});
    end
    checks++;
    if (if_f.counter_H !== 10'd0 || if_f.counter_V !== 10'd0) begin
      errors++; $display("FAIL reset_counters: got H=%0d V=%0d want 0 0", if_f.counter_H, if_f.counter_V);
    end
    checks++;
    if ({if_f.pixel_tick, if_f.frame_tick} !== 2'b00) begin
      errors++; $display("FAIL reset_ticks: got %b want 00", {if_f.pixel_tick, if_f.frame_tick});
    end
    reset = 1'b0;
    @(negedge clk_in);
    checks++;
    if (if_f.pixel_tick !== 1'b1 || if_f.counter_H !== 10'd0) begin
      errors++; $display("FAIL first_tick: got tick=%b H=%0d want 1 0", if_f.pixel_tick, if_f.counter_H);
    end
    @(negedge clk_in);
    checks++;
    if (if_f.pixel_tick !== 1'b0 || if_f.counter_H !== 10'd1) begin
      errors++; $display("FAIL first_step: got tick=%b H=%0d want 0 1", if_f.pixel_tick, if_f.counter_H);
    end
  endtask

  task automatic test_line();
    int step_err = 0, tick_err = 0, hs_low = 0;
    int first_656 = -1, first_low = -1, wrap_v = -1;
    logic [9:0] prev_h;
    logic [9:0] want_h;
    logic       prev_tick;
    restart();
    prev_h    = if_f.counter_H;
    prev_tick = if_f.pixel_tick;
    for (int t = 1; t <= 1700; t++) begin
      @(negedge clk_in);
      want_h = prev_h;
      if (prev_tick) want_h = (prev_h == 10'd799) ? 10'd0 : prev_h + 10'd1;
      if (if_f.counter_H !== want_h) step_err++;
      if (if_f.pixel_tick !== ((t % 2) == 1)) tick_err++;
      if (prev_tick && prev_h == 10'd799 && wrap_v < 0) wrap_v = int'(if_f.counter_V);
      if (if_f.counter_H == 10'd656 && first_656 < 0) first_656 = t;
      if (hsync_f === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = t;
      end
      prev_h    = if_f.counter_H;
      prev_tick = if_f.pixel_tick;
    end
    checks++;
    if (step_err != 0) begin errors++; $display("FAIL h_step: %0d bad steps, want 0", step_err); end
    checks++;
    if (tick_err != 0) begin errors++; $display("FAIL tick_period: %0d bad ticks, want 0", tick_err); end
    checks++;
    if (wrap_v != 1) begin errors++; $display("FAIL h_wrap_v: got V=%0d after wrap want 1", wrap_v); end
    checks++;
    if (first_656 != 1312) begin errors++; $display("FAIL h_656_time: got %0d want 1312", first_656); end
    checks++;
    if (first_low - first_656 != LAT_F + 1) begin
      errors++; $display("FAIL hsync_latency: got %0d want %0d", first_low - first_656, LAT_F + 1);
    end
    checks++;
    if (hs_low != 192) begin errors++; $display("FAIL hsync_width: got %0d clks want 192", hs_low); end
  endtask

  task automatic test_frame();
    int ft_count = 0, ft_first = -1, ft_last = -1, vs_low = 0, vs_first = -1;
    int hs_mis = 0, vs_mis = 0, vid_mis = 0, vid_high = 0;
    logic want_hs, want_vs, want_vid;
    if_s.colour = 1'b1;
    restart();
    for (int t = 0; t <= NS; t++) begin
      if (t > 0) @(negedge clk_in);
      hh[t] = if_s.counter_H; vv[t] = if_s.counter_V;
      hs_a[t] = hsync_s; vs_a[t] = vsync_s; vid_a[t] = video_s; ft_a[t] = if_s.frame_tick;
    end
    for (int t = 0; t <= NS; t++) begin
      if (ft_a[t] === 1'b1) begin
        ft_count++;
        if (ft_first < 0) ft_first = t;
        ft_last = t;
      end
      if (t >= 1 && t <= SFRAME && vs_a[t] === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = t;
      end
      if (t <= SFRAME + 2 && vid_a[t] === 1'b1) vid_high++;
      want_hs = 1'b1; want_vs = 1'b1; want_vid = 1'b0;
      if (t >= DLY_S) begin
        want_hs  = s_hs(hh[t-DLY_S]);
        want_vs  = s_vs(vv[t-DLY_S]);
        want_vid = s_de(hh[t-DLY_S], vv[t-DLY_S]);
      end
      if (hs_a[t] !== want_hs) hs_mis++;
      if (vs_a[t] !== want_vs) vs_mis++;
      if (vid_a[t] !== want_vid) vid_mis++;
    end
    checks++;
    if (ft_count != 2) begin errors++; $display("FAIL frame_tick_count: got %0d want 2", ft_count); end
    checks++;
    if (ft_first != SFRAME || ft_last != 2 * SFRAME) begin
      errors++; $display("FAIL frame_tick_time: got %0d,%0d want %0d,%0d", ft_first, ft_last, SFRAME, 2 * SFRAME);
    end
    checks++;
    if (ft_first >= 0 && (hh[ft_first] !== 10'd0 || vv[ft_first] !== 10'd0)) begin
      errors++; $display("FAIL frame_tick_pos: got H=%0d V=%0d want 0 0", hh[ft_first], vv[ft_first]);
    end
    checks++;
    if (vs_first != 3699) begin errors++; $display("FAIL vsync_start: got %0d want 3699", vs_first); end
    checks++;
    if (vs_low != 224) begin errors++; $display("FAIL vsync_width: got %0d clks want 224", vs_low); end
    checks++;
    if (hs_mis != 0) begin errors++; $display("FAIL hsync_model: %0d samples differ, want 0", hs_mis); end
    checks++;
    if (vs_mis != 0) begin errors++; $display("FAIL vsync_model: %0d samples differ, want 0", vs_mis); end
`ifndef TEST_PATTERN_EN
    checks++;
    if (vid_mis != 0) begin errors++; $display("FAIL video_model: %0d samples differ, want 0", vid_mis); end
    checks++;
    if (vid_high != 2400) begin errors++; $display("FAIL video_count: got %0d clks want 2400", vid_high); end
`endif
  endtask

`ifndef TEST_PATTERN_EN
  task automatic test_colour();
    int mis = 0;
    logic want;
    restart();
    for (int t = 0; t <= 300; t++) begin
      if (t > 0) @(negedge clk_in);
      hh[t] = if_s.counter_H; vv[t] = if_s.counter_V; vid_a[t] = video_s;
      col_a[t] = 1'($urandom_range(0, 1));
      if_s.colour = col_a[t];
    end
    for (int t = 0; t <= 300; t++) begin
      want = 1'b0;
      if (t >= DLY_S) want = s_de(hh[t-DLY_S], vv[t-DLY_S]) & col_a[t-1];
      if (vid_a[t] !== want) mis++;
    end
    checks++;
    if (mis != 0) begin errors++; $display("FAIL colour_gating: %0d samples differ, want 0", mis); end
  endtask
`endif

  task automatic test_midframe_reset();
    int  blank_err = 0;
    bit  found = 0;
    logic want_vid;
    if_s.colour = 1'b1;
    restart();
    for (int t = 0; t < 5000 && !found; t++) begin
      @(negedge clk_in);
      if (if_s.counter_H == 10'd20 && if_s.counter_V == 10'd10) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midreset_reach: got no (20,10) within 5000 clks want reached");
    end else begin
      reset = 1'b1;
      @(negedge clk_in);
      reset = 1'b0;
      checks++;
      if (if_s.counter_H !== 10'd0 || if_s.counter_V !== 10'd0) begin
        errors++; $display("FAIL midreset_counters: got H=%0d V=%0d want 0 0", if_s.counter_H, if_s.counter_V);
      end
      for (int i = 0; i < DLY_S; i++) begin
        if (i > 0) @(negedge clk_in);
        if ({hsync_s, vsync_s, video_s} !== 3'b110 || if_s.frame_tick !== 1'b0) blank_err++;
      end
      checks++;
      if (blank_err != 0) begin errors++; $display("FAIL midreset_blank: %0d bad clks want 0", blank_err); end
      @(negedge clk_in);
`ifdef TEST_PATTERN_EN
      want_vid = 1'b0;
`else
      want_vid = 1'b1;
`endif
      checks++;
      if (video_s !== want_vid || if_s.frame_tick !== 1'b0) begin
        errors++; $display("FAIL midreset_resume: got video=%b ft=%b want %b 0", video_s, if_s.frame_tick, want_vid);
      end
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    bit found;
    if_f.colour = 1'b0;
    restart();
    repeat (LAT_F + 1) @(negedge clk_in);
    checks++;
    if (video_f !== 1'b0) begin errors++; $display("FAIL pattern_0_0: got %b want 0", video_f); end
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk_in);
      if (if_f.counter_H == 10'd32 && if_f.counter_V == 10'd0) found = 1;
    end
    repeat (LAT_F + 1) @(negedge clk_in);
    checks++;
    if (!found || video_f !== 1'b1) begin
      errors++; $display("FAIL pattern_32_0: got %b reached=%0d want 1", video_f, found);
    end
    found = 0;
    for (int t = 0; t < 60000 && !found; t++) begin
      @(negedge clk_in);
      if (if_f.counter_H == 10'd32 && if_f.counter_V == 10'd32) found = 1;
    end
    repeat (LAT_F + 1) @(negedge clk_in);
    checks++;
    if (!found || video_f !== 1'b0) begin
      errors++; $display("FAIL pattern_32_32: got %b reached=%0d want 0", video_f, found);
    end
  endtask
`endif

  initial begin
    if_f.colour = 1'b1;
    if_s.colour = 1'b1;
    test_reset();
    test_line();
    test_frame();
`ifndef TEST_PATTERN_EN
    test_colour();
`endif
    test_midframe_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
